// File: rtl/la_pkg.sv
// Shared types and constants for the logic-analyzer capture controller.
package la_pkg;

    typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} cap_state_t;

    localparam int LA_ENTRIES = 384;
    localparam int LA_AW = 9;
    localparam logic [15:0] AUTOTRIG_LIMIT = 16'hFFFF;

endpackage

// File: rtl/la_capture_ctrl_if.sv
// Command / RAM / trigger signal bundle of the capture controller.
// master: command processor + trigger logic side; slave: capture controller.
interface la_capture_ctrl_if
    import la_pkg::*;
#(
    parameter int AW = LA_AW
) ();

    logic          start;
    logic          abort;
    logic          clr_done;
    logic          wrt_smpl;
    logic          triggered;
    logic [AW-1:0] trig_pos;

    logic          we;
    logic [AW-1:0] waddr;
    logic          armed;
    logic          capturing;
    logic          capture_done;
    logic [AW-1:0] last_addr;
    logic          timed_out;

    modport master (
        output start, abort, clr_done, wrt_smpl, triggered, trig_pos,
        input  we, waddr, armed, capturing, capture_done, last_addr, timed_out
    );

    modport slave (
        input  start, abort, clr_done, wrt_smpl, triggered, trig_pos,
        output we, waddr, armed, capturing, capture_done, last_addr, timed_out
    );

endinterface

// File: rtl/la_wrap_ctr.sv
// AW-bit counter with clear and enable that wraps from ENTRIES-1 back to 0.
// Used as the circular sample-RAM write pointer.
module la_wrap_ctr
    import la_pkg::*;
#(
    parameter int ENTRIES = LA_ENTRIES,
    parameter int AW      = LA_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [AW-1:0] cnt
);

    localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);

    // Clear beats enable so a new capture always starts at address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/la_capture_ctrl.sv
// Logic-analyzer capture sequencer: circular write pointer, pre-trigger fill,
// armed/trigger handshake and post-trigger countdown.
// Optional build macro: LA_CAPTURE_AUTOTRIG_EN (auto-trigger after a long WAIT).
module la_capture_ctrl
    import la_pkg::*;
#(
    parameter int ENTRIES = LA_ENTRIES,
    parameter int AW      = LA_AW
) (
    input logic              clk,
    input logic              rst,
    la_capture_ctrl_if.slave bus
);

    localparam logic [AW-1:0] LAST     = AW'(ENTRIES - 1);
    localparam logic [AW:0]   ARM_BASE = (AW+1)'(ENTRIES);

    cap_state_t    state, state_nxt;
    logic [AW-1:0] tp_eff;
    logic [AW-1:0] smpl_cnt;
    logic [AW-1:0] post_cnt;
    logic [AW-1:0] last_addr_r;
    logic [AW-1:0] waddr;
    logic          armed_r;
    logic          capturing;
    logic          we;
    logic          start_hit;
    logic          abort_hit;
    logic          arm_hit;
    logic          trig_hit;
    logic          post_last;
    logic          auto_fire;

    // trig_pos beyond the buffer depth behaves as the deepest legal position.
    function automatic logic [AW-1:0] clamp_tp(input logic [AW-1:0] tp);
        return (tp > LAST) ? LAST : tp;
    endfunction

    // Address one slot behind the pointer, modulo the buffer depth.
    function automatic logic [AW-1:0] wrap_dec(input logic [AW-1:0] a);
        return (a == '0) ? LAST : a - 1'b1;
    endfunction

    // Event decode shared by the state machine and the datapath registers.
    always_comb begin
        capturing = (state == PRE) || (state == WAIT) || (state == POST);
        we        = bus.wrt_smpl & capturing;
        abort_hit = bus.abort && (state != IDLE);
        start_hit = bus.start && !bus.abort && (state == IDLE);
        arm_hit   = (state == PRE) && we &&
                    (({1'b0, smpl_cnt} + 1'b1) == (ARM_BASE - {1'b0, tp_eff}));
        trig_hit  = (state == WAIT) && (bus.triggered || auto_fire);
        post_last = (state == POST) && we && ((post_cnt + 1'b1) == tp_eff);
    end

    la_wrap_ctr #(
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_waddr (
        .clk (clk),
        .rst (rst),
        .clr (start_hit),
        .en  (we),
        .cnt (waddr)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort from any active state wins over everything else.
    always_comb begin
        state_nxt = state;
        if (abort_hit) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start_hit) state_nxt = PRE;
                PRE:  if (arm_hit)   state_nxt = WAIT;
                WAIT: if (trig_hit)  state_nxt = (tp_eff == '0) ? DONE : POST;
                POST: if (post_last) state_nxt = DONE;
                DONE: if (bus.clr_done) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Fill / countdown counters, latched trigger position and final address.
    always_ff @(posedge clk) begin
        if (rst) begin
            tp_eff      <= '0;
            smpl_cnt    <= '0;
            post_cnt    <= '0;
            last_addr_r <= '0;
            armed_r     <= 1'b0;
        end else begin
            armed_r <= (state_nxt == WAIT) || (state_nxt == POST);
            if (start_hit) begin
                tp_eff   <= clamp_tp(bus.trig_pos);
                smpl_cnt <= '0;
                post_cnt <= '0;
            end
            if ((state == PRE) && we) begin
                smpl_cnt <= smpl_cnt + 1'b1;
            end
            if (trig_hit) begin
                post_cnt <= '0;
            end
            if ((state == POST) && we) begin
                post_cnt <= post_cnt + 1'b1;
            end
            if (!abort_hit) begin
                if (post_last) begin
                    last_addr_r <= waddr;
                end else if (trig_hit && (tp_eff == '0)) begin
                    // With no post-trigger window the trigger cycle ends the capture.
                    last_addr_r <= we ? waddr : wrap_dec(waddr);
                end
            end
        end
    end

`ifdef LA_CAPTURE_AUTOTRIG_EN
    logic [15:0] wait_cnt;
    logic        timed_out_r;

    assign auto_fire = (state == WAIT) && we && (wait_cnt == AUTOTRIG_LIMIT - 16'd1);

    // Count WAIT writes; the write that reaches the limit acts as the trigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            timed_out_r <= 1'b0;
        end else begin
            if (start_hit) begin
                wait_cnt <= '0;
            end else if ((state == WAIT) && we) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (abort_hit || start_hit) begin
                timed_out_r <= 1'b0;
            end else if (auto_fire) begin
                timed_out_r <= 1'b1;
            end
        end
    end

    assign bus.timed_out = timed_out_r;
`else
    assign auto_fire     = 1'b0;
    assign bus.timed_out = 1'b0;
`endif

    assign bus.we           = we;
    assign bus.waddr        = waddr;
    assign bus.armed        = armed_r;
    assign bus.capturing    = capturing;
    assign bus.capture_done = (state == DONE);
    assign bus.last_addr    = last_addr_r;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl: a vector table for short handshakes plus
// hand-written multi-cycle capture sequences.
module tb_la_capture_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    la_capture_ctrl_if bus ();

    la_capture_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       start;
        logic       abort;
        logic       clr;
        logic       wrt;
        logic       trig;
        logic [8:0] tp;
        logic       e_we;
        logic [8:0] e_waddr;
        logic       e_armed;
        logic       e_cap;
        logic       e_done;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic s, input logic a, input logic c,
                                input logic w, input logic t, input logic [8:0] tp,
                                input logic ewe, input logic [8:0] ewa,
                                input logic earm, input logic ecap, input logic edone);
        vec_t v;
        v.start = s; v.abort = a; v.clr = c; v.wrt = w; v.trig = t; v.tp = tp;
        v.e_we = ewe; v.e_waddr = ewa; v.e_armed = earm; v.e_cap = ecap; v.e_done = edone;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.clr_done  = 1'b0;
        bus.wrt_smpl  = 1'b0;
        bus.triggered = 1'b0;
    endtask

    task automatic pulse_start(input logic [8:0] tp);
        bus.trig_pos = tp;
        bus.start    = 1'b1;
        cyc();
        bus.start    = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr_done = 1'b1;
        cyc();
        bus.clr_done = 1'b0;
    endtask

    localparam int AUTO_N = 374 + 65535 + 10;

    initial begin
        idle_inputs();
        bus.trig_pos = 9'd0;
        rst = 1'b1;

        // Reset: two cycles with wrt_smpl toggling and start asserted.
        bus.start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.wrt_smpl = (i == 0);
            #1;
            chk("rst_we", 32'(bus.we), 32'd0);
            cyc();
            chk("rst_waddr", 32'(bus.waddr), 32'd0);
            chk("rst_armed", 32'(bus.armed), 32'd0);
            chk("rst_done", 32'(bus.capture_done), 32'd0);
            chk("rst_timed_out", 32'(bus.timed_out), 32'd0);
        end
        rst = 1'b0;
        idle_inputs();
        cyc();
        chk("rst_last_addr", 32'(bus.last_addr), 32'd0);
        chk("rst_capturing", 32'(bus.capturing), 32'd0);

        // Vector table: clamp, early arm, trigger, start-while-capturing, abort.
        vecs[0] = mk(1, 0, 0, 1, 0, 9'd500, 0, 9'd0, 0, 1, 0);
        vecs[1] = mk(0, 0, 0, 1, 0, 9'd0,   1, 9'd1, 1, 1, 0);
        vecs[2] = mk(0, 0, 0, 0, 1, 9'd0,   0, 9'd1, 1, 1, 0);
        vecs[3] = mk(0, 0, 0, 1, 0, 9'd0,   1, 9'd2, 1, 1, 0);
        vecs[4] = mk(1, 0, 0, 0, 0, 9'd0,   0, 9'd2, 1, 1, 0);
        vecs[5] = mk(0, 1, 0, 1, 0, 9'd0,   1, 9'd3, 0, 0, 0);
        vecs[6] = mk(0, 0, 0, 1, 0, 9'd0,   0, 9'd3, 0, 0, 0);
        vecs[7] = mk(1, 0, 0, 0, 0, 9'd383, 0, 9'd0, 0, 1, 0);
        vecs[8] = mk(0, 0, 0, 1, 0, 9'd0,   1, 9'd1, 1, 1, 0);
        vecs[9] = mk(0, 0, 0, 1, 1, 9'd0,   1, 9'd2, 1, 1, 0);
        for (int i = 0; i < NV; i++) begin
            bus.start     = vecs[i].start;
            bus.abort     = vecs[i].abort;
            bus.clr_done  = vecs[i].clr;
            bus.wrt_smpl  = vecs[i].wrt;
            bus.triggered = vecs[i].trig;
            bus.trig_pos  = vecs[i].tp;
            #1;
            chk($sformatf("vec%0d_we", i), 32'(bus.we), 32'(vecs[i].e_we));
            cyc();
            chk($sformatf("vec%0d_waddr", i), 32'(bus.waddr), 32'(vecs[i].e_waddr));
            chk($sformatf("vec%0d_armed", i), 32'(bus.armed), 32'(vecs[i].e_armed));
            chk($sformatf("vec%0d_capturing", i), 32'(bus.capturing), 32'(vecs[i].e_cap));
            chk($sformatf("vec%0d_done", i), 32'(bus.capture_done), 32'(vecs[i].e_done));
            chk($sformatf("vec%0d_last_addr", i), 32'(bus.last_addr), 32'd0);
        end
        idle_inputs();

        // Reset in the middle of a capture.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_waddr", 32'(bus.waddr), 32'd0);
        chk("midrst_capturing", 32'(bus.capturing), 32'd0);
        chk("midrst_armed", 32'(bus.armed), 32'd0);

        // Basic capture: trig_pos=100, trigger on write 400.
        pulse_start(9'd100);
        for (int i = 1; i <= 500; i++) begin
            bus.wrt_smpl  = 1'b1;
            bus.triggered = (i == 400);
            cyc();
            if (i == 283) chk("basic_armed_283", 32'(bus.armed), 32'd0);
            if (i == 284) chk("basic_armed_284", 32'(bus.armed), 32'd1);
            if (i == 499) chk("basic_done_499", 32'(bus.capture_done), 32'd0);
        end
        bus.triggered = 1'b0;
        chk("basic_done_500", 32'(bus.capture_done), 32'd1);
        chk("basic_last_addr", 32'(bus.last_addr), 32'd115);
        chk("basic_armed_done", 32'(bus.armed), 32'd0);
        #1;
        chk("basic_we_in_done", 32'(bus.we), 32'd0);
        cyc();
        chk("basic_waddr_frozen", 32'(bus.waddr), 32'd116);
        bus.wrt_smpl = 1'b0;

        // DONE handshakes: start alone ignored; start+clr_done returns to idle only.
        pulse_start(9'd5);
        chk("done_start_ignored", 32'(bus.capture_done), 32'd1);
        chk("done_start_no_capture", 32'(bus.capturing), 32'd0);
        bus.start    = 1'b1;
        bus.clr_done = 1'b1;
        cyc();
        idle_inputs();
        chk("clr_start_done", 32'(bus.capture_done), 32'd0);
        chk("clr_start_capturing", 32'(bus.capturing), 32'd0);
        cyc();
        chk("clr_start_still_idle", 32'(bus.capturing), 32'd0);
        chk("clr_start_waddr", 32'(bus.waddr), 32'd116);
        chk("clr_start_last_addr", 32'(bus.last_addr), 32'd115);

        // Early trigger held from start: ignored until armed after 84 writes.
        pulse_start(9'd300);
        bus.triggered = 1'b1;
        for (int i = 1; i <= 84; i++) begin
            bus.wrt_smpl = 1'b1;
            cyc();
            if (i == 83) begin
                chk("early_armed_83", 32'(bus.armed), 32'd0);
                chk("early_cap_83", 32'(bus.capturing), 32'd1);
            end
        end
        chk("early_armed_84", 32'(bus.armed), 32'd1);
        bus.wrt_smpl = 1'b0;
        cyc();
        for (int i = 1; i <= 300; i++) begin
            bus.wrt_smpl = 1'b1;
            cyc();
            if (i == 299) chk("early_done_299", 32'(bus.capture_done), 32'd0);
        end
        idle_inputs();
        chk("early_done_300", 32'(bus.capture_done), 32'd1);
        chk("early_last_addr", 32'(bus.last_addr), 32'd383);
        pulse_clr();

        // trig_pos=0: armed after a full buffer, trigger ends capture on the same edge.
        pulse_start(9'd0);
        for (int i = 1; i <= 384; i++) begin
            bus.wrt_smpl = 1'b1;
            cyc();
            if (i == 383) chk("tp0_armed_383", 32'(bus.armed), 32'd0);
        end
        chk("tp0_armed_384", 32'(bus.armed), 32'd1);
        bus.wrt_smpl  = 1'b0;
        bus.triggered = 1'b1;
        cyc();
        idle_inputs();
        chk("tp0_done", 32'(bus.capture_done), 32'd1);
        chk("tp0_last_addr", 32'(bus.last_addr), 32'd383);
        chk("tp0_waddr", 32'(bus.waddr), 32'd0);
        chk("tp0_armed", 32'(bus.armed), 32'd0);
        pulse_clr();

        // Long WAIT with no trigger: auto-trigger only when the option is built in.
        pulse_start(9'd10);
        bus.wrt_smpl = 1'b1;
        for (int i = 1; i <= AUTO_N; i++) begin
            cyc();
        end
        idle_inputs();
`ifdef LA_CAPTURE_AUTOTRIG_EN
        chk("auto_done", 32'(bus.capture_done), 32'd1);
        chk("auto_timed_out", 32'(bus.timed_out), 32'd1);
        chk("auto_last_addr", 32'(bus.last_addr), 32'((AUTO_N - 1) % 384));
`else
        chk("noauto_done", 32'(bus.capture_done), 32'd0);
        chk("noauto_capturing", 32'(bus.capturing), 32'd1);
        chk("noauto_armed", 32'(bus.armed), 32'd1);
        chk("noauto_timed_out", 32'(bus.timed_out), 32'd0);
`endif
        bus.abort = 1'b1;
        cyc();
        bus.abort = 1'b0;
        chk("final_abort_capturing", 32'(bus.capturing), 32'd0);
        chk("final_abort_timed_out", 32'(bus.timed_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
